// File: rtl/div_arb_pkg.sv
// Shared types and helpers for the round-robin shared divider.
// Holds the FSM state encoding, the default operand width and a clog2 that never returns 0.
package div_arb_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shared_divider_arb_if.sv
// Client-side bundle of the shared divider: per-client request/operands in, grant and result out.
// The master modport is the client side and the slave modport is the divider side.
interface shared_divider_arb_if import div_arb_pkg::*; #(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int N_CLIENTS = 2,
  parameter int ID_WIDTH  = clog2_min1(N_CLIENTS)
) ();

  logic [N_CLIENTS-1:0]       req;
  logic [N_CLIENTS*WIDTH-1:0] dividend;
  logic [N_CLIENTS*WIDTH-1:0] divisor;
  logic [N_CLIENTS-1:0]       grant;
  logic                       busy;
  logic                       valid;
  logic [WIDTH-1:0]           quotient;
  logic [WIDTH-1:0]           remainder;
  logic [ID_WIDTH-1:0]        res_id;
  logic                       div_by_zero;

  modport master (
    output req, dividend, divisor,
    input  grant, busy, valid, quotient, remainder, res_id, div_by_zero
  );

  modport slave (
    input  req, dividend, divisor,
    output grant, busy, valid, quotient, remainder, res_id, div_by_zero
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past last_winner and wraps modulo N.
// Zero latency; winner is all-zero when no request is set.
module rr_arbiter import div_arb_pkg::*; #(
  parameter int N    = 2,
  parameter int ID_W = clog2_min1(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last_winner,
  output logic [N-1:0]    winner,
  output logic [ID_W-1:0] winner_idx
);

  always_comb begin
    int   idx;
    logic found;
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    idx        = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_winner) + k) % N;
      if (!found && req[idx]) begin
        found         = 1'b1;
        winner[idx]   = 1'b1;
        winner_idx    = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/shared_divider_arb.sv
// Round-robin shared restoring divider: grant one cycle after req, result WIDTH+1 cycles after req (2 on /0).
// Requests are only taken in IDLE; clients hold req and operands until they see their grant pulse.
module shared_divider_arb import div_arb_pkg::*; #(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int N_CLIENTS = 2,
  parameter int ID_WIDTH  = clog2_min1(N_CLIENTS)
) (
  input logic                 clock,
  input logic                 reset,
  shared_divider_arb_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t               state, state_nxt;
  logic [N_CLIENTS-1:0] winner;
  logic [ID_WIDTH-1:0]  winner_idx, last_winner, cur_id;
  logic                 any_req;
  logic [WIDTH-1:0]     sel_dividend, sel_divisor;
  logic [WIDTH-1:0]     dvsr, q_sh, prem;
  logic [WIDTH:0]       shifted;
  logic                 step_ok, last_step, dz;
  logic [WIDTH-1:0]     q_step, prem_step;
  logic [CNT_W-1:0]     cnt;

  rr_arbiter #(.N(N_CLIENTS), .ID_W(ID_WIDTH)) u_arb (
    .req         (bus.req),
    .last_winner (last_winner),
    .winner      (winner),
    .winner_idx  (winner_idx)
  );

  // q_sh starts as the dividend and fills with quotient bits as the dividend bits shift out.
  always_comb begin
    any_req      = |bus.req;
    sel_dividend = bus.dividend[int'(winner_idx)*WIDTH +: WIDTH];
    sel_divisor  = bus.divisor[int'(winner_idx)*WIDTH +: WIDTH];
    shifted      = {prem, q_sh[WIDTH-1]};
    step_ok      = (shifted >= {1'b0, dvsr});
    prem_step    = step_ok ? WIDTH'(shifted - {1'b0, dvsr}) : shifted[WIDTH-1:0];
    q_step       = WIDTH'({q_sh, step_ok});
    last_step    = (cnt == CNT_W'(1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = (sel_divisor == '0) ? DONE : DIV;
      DIV:     if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      last_winner     <= ID_WIDTH'(N_CLIENTS - 1);
      cur_id          <= '0;
      dvsr            <= '0;
      q_sh            <= '0;
      prem            <= '0;
      cnt             <= '0;
      dz              <= 1'b0;
      bus.grant       <= '0;
      bus.busy        <= 1'b0;
      bus.valid       <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.res_id      <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      state     <= state_nxt;
      bus.busy  <= (state_nxt != IDLE);
      bus.grant <= '0;
      bus.valid <= 1'b0;
      case (state)
        IDLE: if (any_req) begin
          bus.grant   <= winner;
          last_winner <= winner_idx;
          cur_id      <= winner_idx;
          q_sh        <= sel_dividend;
          dvsr        <= sel_divisor;
          prem        <= '0;
          cnt         <= CNT_W'(WIDTH);
          dz          <= (sel_divisor == '0);
        end
        // Results land with the final quotient bit so valid coincides with the DONE cycle.
        DIV: begin
          q_sh <= q_step;
          prem <= prem_step;
          cnt  <= cnt - CNT_W'(1);
          if (last_step) begin
            bus.valid       <= 1'b1;
            bus.quotient    <= q_step;
            bus.remainder   <= prem_step;
            bus.res_id      <= cur_id;
            bus.div_by_zero <= 1'b0;
          end
        end
        // A zero divisor skips DIV entirely; q_sh still holds the untouched dividend.
        DONE: if (dz) begin
          bus.valid       <= 1'b1;
          bus.quotient    <= '1;
          bus.remainder   <= q_sh;
          bus.res_id      <= cur_id;
          bus.div_by_zero <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
